// File: rtl/btn_mode_ctrl.sv
// Alarm-clock button controller: arbitrates conditioned button presses, runs the
// clock/adjust/ringing mode FSM and emits inc/dec strobes with hold-to-repeat.
module btn_mode_ctrl #(
  parameter int unsigned     HOLD_CYC = 50_000_000,
  parameter int unsigned     REP_CYC  = 12_500_000,
  parameter longint unsigned RING_CYC = 64'd3_000_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_btn_pulse,  // {right, left, down, up, center}
  input  logic [4:0] i_btn_level,
  input  logic       i_alarm_match,
  input  logic       i_alarm_en,
  output logic       o_adj_mode,
  output logic [1:0] o_field_sel,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_ringing
);

  localparam int unsigned RepMax = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam int unsigned RingW  = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;

  typedef enum logic [2:0] {
    StClock, StAdjHr, StAdjMin, StAdjAhr, StAdjAmin, StRinging
  } state_t;

  state_t             r_state;
  logic               r_adj_mode;
  logic [1:0]         r_field_sel;
  logic               r_inc;
  logic               r_dec;
  logic               r_ringing;
  logic               r_rep_act;    // auto-repeat armed
  logic               r_rep_dn;     // 0: repeating up, 1: repeating down
  logic               r_rep_phase;  // 0: initial hold, 1: repeat interval
  logic [RepW-1:0]    r_rep_cnt;
  logic [RingW-1:0]   r_ring_cnt;

  logic w_ctr, w_up, w_dn, w_lf, w_rt, w_any, w_alarm;
  logic w_rep_lvl, w_rep_hit, w_ring_done;
  logic w_unused_lvl;

  // Fixed-priority arbitration: center > up > down > left > right.
  always_comb begin
    w_ctr       = i_btn_pulse[0];
    w_up        = i_btn_pulse[1] & ~i_btn_pulse[0];
    w_dn        = i_btn_pulse[2] & ~|i_btn_pulse[1:0];
    w_lf        = i_btn_pulse[3] & ~|i_btn_pulse[2:0];
    w_rt        = i_btn_pulse[4] & ~|i_btn_pulse[3:0];
    w_any       = |i_btn_pulse;
    w_alarm     = i_alarm_match & i_alarm_en;
    w_rep_lvl   = r_rep_dn ? i_btn_level[2] : i_btn_level[1];
    w_rep_hit   = r_rep_phase ? (r_rep_cnt == RepW'(REP_CYC - 1))
                              : (r_rep_cnt == RepW'(HOLD_CYC - 1));
    w_ring_done = (r_ring_cnt == RingW'(RING_CYC - 64'd1));
  end

  // Only the up/down levels drive auto-repeat.
  assign w_unused_lvl = ^{i_btn_level[4:3], i_btn_level[0]};

  function automatic state_t adj_state(input logic [1:0] f);
    unique case (f)
      2'd0:    adj_state = StAdjHr;
      2'd1:    adj_state = StAdjMin;
      2'd2:    adj_state = StAdjAhr;
      default: adj_state = StAdjAmin;
    endcase
  endfunction

  // Mode FSM with registered outputs, auto-repeat and ring timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StClock;
      r_adj_mode  <= 1'b0;
      r_field_sel <= 2'd0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_ringing   <= 1'b0;
      r_rep_act   <= 1'b0;
      r_rep_dn    <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_cnt   <= '0;
      r_ring_cnt  <= '0;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      unique case (r_state)
        StClock: begin
          r_rep_act <= 1'b0;
          r_rep_cnt <= '0;
          if (w_alarm) begin
            r_state    <= StRinging;
            r_ringing  <= 1'b1;
            r_ring_cnt <= '0;
          end else if (w_ctr) begin
            r_state     <= StAdjHr;
            r_adj_mode  <= 1'b1;
            r_field_sel <= 2'd0;
          end
        end
        StRinging: begin
          // Any press only silences the alarm; it is not forwarded.
          if (w_any || w_ring_done) begin
            r_state    <= StClock;
            r_ringing  <= 1'b0;
            r_ring_cnt <= '0;
          end else begin
            r_ring_cnt <= r_ring_cnt + RingW'(1);
          end
        end
        default: begin
          if (w_ctr) begin
            r_state    <= StClock;
            r_adj_mode <= 1'b0;
            r_rep_act  <= 1'b0;
            r_rep_cnt  <= '0;
          end else if (w_up || w_dn) begin
            r_inc       <= w_up;
            r_dec       <= w_dn;
            r_rep_act   <= 1'b1;
            r_rep_dn    <= w_dn;
            r_rep_phase <= 1'b0;
            r_rep_cnt   <= '0;
          end else if (w_lf || w_rt) begin
            r_field_sel <= w_rt ? r_field_sel + 2'd1 : r_field_sel - 2'd1;
            r_state     <= adj_state(w_rt ? r_field_sel + 2'd1 : r_field_sel - 2'd1);
            r_rep_act   <= 1'b0;
            r_rep_cnt   <= '0;
          end else if (r_rep_act) begin
            if (!w_rep_lvl) begin
              r_rep_act <= 1'b0;
              r_rep_cnt <= '0;
            end else if (w_rep_hit) begin
              r_inc       <= ~r_rep_dn;
              r_dec       <= r_rep_dn;
              r_rep_phase <= 1'b1;
              r_rep_cnt   <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + RepW'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_adj_mode  = r_adj_mode;
  assign o_field_sel = r_field_sel;
  assign o_inc       = r_inc;
  assign o_dec       = r_dec;
  assign o_ringing   = r_ringing;

endmodule
